// File: rtl/module_uart_rx_ctrl.sv
// UART 8N1 receiver/control stage feeding the UART data register file.
// Oversamples rxd_i through a 2-flop synchronizer, assembles LSB-first
// frames, writes each good byte (zero-extended) via a one-cycle wr_2_o
// strobe and keeps sticky new-data / overrun / frame-error status.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit).
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   rxd_i        asynchronous serial line, idle high
//   clr_new_i    one-cycle clear of all sticky status flags
//   rx_data_o    last good byte, zero-extended to DATA_W
//   wr_2_o       one-cycle register-file write strobe
//   rx_new_o     sticky: unread byte available
//   overrun_o    sticky: byte written while rx_new_o still set
//   frame_err_o  sticky: stop bit sampled low
//   parity_err_o sticky: parity mismatch (0 without UART_RX_PARITY_EN)
//   busy_o       receiver not idle
module module_uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rxd_i,
    input  logic              clr_new_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              wr_2_o,
    output logic              rx_new_o,
    output logic              overrun_o,
    output logic              frame_err_o,
    output logic              parity_err_o,
    output logic              busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK,
        S_WRITE
    } state_t;

    state_t            r_state;
    state_t            w_nx;
    logic              r_sync1;
    logic              r_sync2;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_idx;
    logic [7:0]        r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_wr;
    logic              r_new;
    logic              r_ovr;
    logic              r_fe;
    logic              r_pe;
    logic              w_rx_s;
    logic              w_half;
    logic              w_full;
    logic              w_cnt_rst;
    logic              w_sample;
    logic              w_set_fe;
    logic              w_set_pe;
    logic              w_set_new;
    logic              w_set_ovr;
    logic              w_par_bad;

    assign w_rx_s = r_sync2;
    assign w_half = (r_cnt == HALF);
    assign w_full = (r_cnt == FULL);

    // Synchronizer presets to the idle level so reset never fakes a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nx;
        end
    end

    always_comb begin
        w_nx      = r_state;
        w_cnt_rst = 1'b0;
        w_sample  = 1'b0;
        w_set_fe  = 1'b0;
        w_set_pe  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_nx      = S_START;
                    w_cnt_rst = 1'b1;
                end
            end
            S_START: begin
                // Line back high at mid start bit: treat as a glitch.
                if (w_half) begin
                    w_cnt_rst = 1'b1;
                    w_nx      = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full) begin
                    w_cnt_rst = 1'b1;
                    w_sample  = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_nx = S_PARITY;
`else
                        w_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full) begin
                    w_cnt_rst = 1'b1;
                    w_set_pe  = (w_rx_s != ^r_shift);
                    w_nx      = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_full) begin
                    w_cnt_rst = 1'b1;
                    if (!w_rx_s) begin
                        w_set_fe = 1'b1;
                        w_nx     = S_BREAK;
                    end else if (w_par_bad) begin
                        w_nx = S_IDLE;
                    end else begin
                        w_nx = S_WRITE;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_nx = S_IDLE;
                end
            end
            S_WRITE: begin
                w_nx = S_IDLE;
            end
            default: begin
                w_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= w_cnt_rst ? '0 : r_cnt + CW'(1);
            if (r_state == S_START) begin
                r_idx <= '0;
            end else if (w_sample) begin
                r_idx          <= r_idx + 3'd1;
                r_shift[r_idx] <= w_rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;

    // Per-frame mismatch flag, kept until the stop bit decides the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_par_bad <= 1'b0;
        end else if (r_state == S_START) begin
            r_par_bad <= 1'b0;
        end else if (w_set_pe) begin
            r_par_bad <= 1'b1;
        end
    end

    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // Write data and strobe are loaded on entry to WRITE so both are
    // visible together during the WRITE cycle.
    assign w_set_new = (w_nx == S_WRITE);
    assign w_set_ovr = w_set_new & r_new & ~clr_new_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_wr   <= 1'b0;
            r_new  <= 1'b0;
            r_ovr  <= 1'b0;
            r_fe   <= 1'b0;
            r_pe   <= 1'b0;
        end else begin
            r_wr <= w_set_new;
            if (w_set_new) begin
                r_data <= {{(DATA_W-8){1'b0}}, r_shift};
            end
            // A flag being set wins over a same-cycle clear.
            r_new <= w_set_new | (r_new & ~clr_new_i);
            r_ovr <= w_set_ovr | (r_ovr & ~clr_new_i);
            r_fe  <= w_set_fe  | (r_fe  & ~clr_new_i);
            r_pe  <= w_set_pe  | (r_pe  & ~clr_new_i);
        end
    end

    assign rx_data_o    = r_data;
    assign wr_2_o       = r_wr;
    assign rx_new_o     = r_new;
    assign overrun_o    = r_ovr;
    assign frame_err_o  = r_fe;
    assign parity_err_o = r_pe;
    assign busy_o       = (r_state != S_IDLE);

endmodule
